// File: rtl/sys_bus_loader.sv
// Boot loader and bus decoder: streams a program image into RAM, then runs the
// processor against RAM plus a small bank of memory-mapped output registers.
module sys_bus_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int N_OUT    = 4,
  parameter int IO_BASE  = 240,
  parameter int PROG_LEN = 240,
  parameter int TIMEOUT  = 8500,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_valid,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    ld_ready,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    cpu_we,
  input  logic                    cpu_halt,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_run,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_din,
  output logic                    ram_we,
  input  logic [DATA_W-1:0]       ram_dout,
  output logic [N_OUT*DATA_W-1:0] io_out,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic                    timeout
);

  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [ADDR_W:0]   IO_BASE_X = (ADDR_W+1)'(IO_BASE);
  localparam logic [ADDR_W:0]   IO_END_X  = (ADDR_W+1)'(IO_BASE + N_OUT);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(PROG_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] io_q [N_OUT];
  logic [DATA_W-1:0] io_d [N_OUT];

  logic              in_load, in_run, ld_accept, at_limit, halt_now;
  logic [ADDR_W:0]   addr_x, io_off_x;
  logic              is_ram, is_io;
  logic [IDX_W-1:0]  io_idx;

  assign in_load   = (state_q == S_LOAD);
  assign in_run    = (state_q == S_RUN);
  assign ld_ready  = rst_n && in_load;
  assign ld_accept = ld_valid && ld_ready;
  assign at_limit  = (cycle_cnt_q == CNT_LAST);
  assign halt_now  = in_run && (cpu_halt || at_limit);

  // Widen by one bit so the I/O window compare cannot wrap at the top of the map.
  assign addr_x   = {1'b0, cpu_addr};
  assign is_ram   = (addr_x < IO_BASE_X);
  assign is_io    = (addr_x >= IO_BASE_X) && (addr_x < IO_END_X);
  assign io_off_x = addr_x - IO_BASE_X;
  assign io_idx   = io_off_x[IDX_W-1:0];

  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    cycle_cnt_d = cycle_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_LOAD: begin
        if (ld_accept) begin
          load_ptr_d = load_ptr_q + 1'b1;
          if (load_ptr_q == LAST_PTR) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_now) begin
          state_d = S_HALT;
          if (at_limit) timeout_d = 1'b1;
        end else begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_addr  = in_load ? load_ptr_q : cpu_addr;
    ram_din   = in_load ? ld_data : cpu_wdata;
    ram_we    = ld_accept || (rst_n && in_run && cpu_we && is_ram);
    cpu_rdata = '0;
    if (in_run) begin
      if (is_ram)     cpu_rdata = ram_dout;
      else if (is_io) cpu_rdata = io_q[io_idx];
    end
  end

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_io
      logic io_we;
      assign io_we     = in_run && cpu_we && is_io && (io_idx == IDX_W'(gi));
      assign io_d[gi]  = io_we ? cpu_wdata : io_q[gi];
      assign io_out[gi*DATA_W +: DATA_W] = io_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      load_ptr_q  <= '0;
      cycle_cnt_q <= '0;
      timeout_q   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) io_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      load_ptr_q  <= load_ptr_d;
      cycle_cnt_q <= cycle_cnt_d;
      timeout_q   <= timeout_d;
      for (int i = 0; i < N_OUT; i++) io_q[i] <= io_d[i];
    end
  end

  assign cpu_run   = in_run;
  assign cycle_cnt = cycle_cnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sys_bus_loader.sv
// Directed bench for sys_bus_loader: load, I/O map, halt, timeout and reset cases
// against a registered-read RAM model.
module tb_sys_bus_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_halt;
  logic [7:0]  cpu_rdata;
  logic        cpu_run;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [31:0] io_out;
  logic [15:0] cycle_cnt;
  logic        timeout;

  logic [7:0]  mem [256];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  sys_bus_loader dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_halt(cpu_halt),
    .cpu_rdata(cpu_rdata), .cpu_run(cpu_run),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .io_out(io_out), .cycle_cnt(cycle_cnt), .timeout(timeout)
  );

  task automatic next_cycle;
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_idle;
    ld_valid = 0; ld_data = 0; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_halt = 0;
  endtask

  task automatic load_bytes(input int start, input int n, input logic [7:0] mask, input bit gaps);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 3 == 1)) begin
        ld_valid = 0; #1;
        n_checks++;
        if (ram_we !== 1'b0 || ld_ready !== 1'b1)
          $display("FAIL load_gap k=%0d: ram_we=%b ld_ready=%b, required 0/1", k, ram_we, ld_ready);
        else n_pass++;
        next_cycle;
      end
      d = 8'(start + k) ^ mask;
      ld_valid = 1; ld_data = d; #1;
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== 8'(start + k) || ram_din !== d || cpu_run !== 1'b0)
        $display("FAIL load_byte k=%0d: we=%b addr=%0d din=%h run=%b, required 1/%0d/%h/0",
                 start + k, ram_we, ram_addr, ram_din, cpu_run, start + k, d);
      else n_pass++;
      next_cycle;
    end
    ld_valid = 0;
  endtask

  task automatic test_reset;
    set_idle;
    rst_n = 0; ld_valid = 1; ld_data = 8'h11; cpu_we = 1; cpu_addr = 8'h05;
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if (ram_we !== 1'b0 || ld_ready !== 1'b0)
      $display("FAIL reset_bus: ram_we=%b ld_ready=%b, required 0/0", ram_we, ld_ready);
    else n_pass++;
    n_checks++;
    if (cpu_run !== 1'b0 || cycle_cnt !== 16'd0 || timeout !== 1'b0 || io_out !== 32'd0)
      $display("FAIL reset_state: run=%b cnt=%0d to=%b io=%h, required 0/0/0/0",
               cpu_run, cycle_cnt, timeout, io_out);
    else n_pass++;
    rst_n = 1; set_idle; cpu_addr = 8'h05; #1;
    n_checks++;
    if (ld_ready !== 1'b1 || ram_we !== 1'b0 || cpu_rdata !== 8'd0)
      $display("FAIL reset_release: ld_ready=%b ram_we=%b rdata=%h, required 1/0/00",
               ld_ready, ram_we, cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_load;
    int bad;
    load_bytes(0, 240, 8'h00, 1'b1);
    cyc = 0; #1;
    n_checks++;
    if (cpu_run !== 1'b1 || ld_ready !== 1'b0 || cycle_cnt !== 16'd0)
      $display("FAIL run_entry: run=%b ld_ready=%b cnt=%0d, required 1/0/0", cpu_run, ld_ready, cycle_cnt);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 240; k++) if (mem[k] !== 8'(k)) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL ram_image: %0d bytes differ, required 0", bad);
    else n_pass++;
    ld_valid = 1; ld_data = 8'h42; #1;
    n_checks++;
    if (ram_we !== 1'b0)
      $display("FAIL load_after_run: ram_we=%b, required 0", ram_we);
    else n_pass++;
  endtask

  task automatic test_io_map;
    // cycle 0: write io register 1
    cpu_addr = 8'd241; cpu_wdata = 8'hA5; cpu_we = 1; #1;
    n_checks++;
    if (ram_we !== 1'b0 || ram_addr !== 8'd241)
      $display("FAIL io_write_bus: ram_we=%b ram_addr=%0d, required 0/241", ram_we, ram_addr);
    else n_pass++;
    next_cycle;
    ld_valid = 0; cpu_we = 0; #1;
    n_checks++;
    if (io_out !== 32'h0000A500 || cpu_rdata !== 8'hA5)
      $display("FAIL io_readback: io=%h rdata=%h, required 0000a500/a5", io_out, cpu_rdata);
    else n_pass++;
    next_cycle;
    cpu_addr = 8'd250; cpu_wdata = 8'h5A; cpu_we = 1; #1;
    n_checks++;
    if (ram_we !== 1'b0 || cpu_rdata !== 8'd0)
      $display("FAIL unmapped: ram_we=%b rdata=%h, required 0/00", ram_we, cpu_rdata);
    else n_pass++;
    next_cycle;
    cpu_addr = 8'd10; cpu_wdata = 8'h3C; cpu_we = 1; #1;
    n_checks++;
    if (io_out !== 32'h0000A500 || ram_we !== 1'b1 || ram_din !== 8'h3C || ram_addr !== 8'd10)
      $display("FAIL ram_write: io=%h we=%b din=%h addr=%0d, required 0000a500/1/3c/10",
               io_out, ram_we, ram_din, ram_addr);
    else n_pass++;
    next_cycle;
    cpu_we = 0; #1;
    n_checks++;
    if (cpu_rdata !== 8'h0A)
      $display("FAIL ram_read_latency: rdata=%h, required 0a", cpu_rdata);
    else n_pass++;
    next_cycle; #1;
    n_checks++;
    if (cpu_rdata !== 8'h3C)
      $display("FAIL ram_read: rdata=%h, required 3c", cpu_rdata);
    else n_pass++;
    cpu_addr = 8'd243; cpu_wdata = 8'hC3; cpu_we = 1;
    next_cycle;
    cpu_we = 0; #1;
    n_checks++;
    if (io_out !== 32'hC300A500 || cycle_cnt !== 16'(cyc))
      $display("FAIL io_reg3: io=%h cnt=%0d, required c300a500/%0d", io_out, cycle_cnt, cyc);
    else n_pass++;
  endtask

  task automatic test_halt_request;
    while (cyc < 10) next_cycle;
    #1;
    n_checks++;
    if (cycle_cnt !== 16'd10 || cpu_run !== 1'b1)
      $display("FAIL pre_halt: cnt=%0d run=%b, required 10/1", cycle_cnt, cpu_run);
    else n_pass++;
    cpu_halt = 1;
    next_cycle;
    cpu_halt = 0; cpu_addr = 8'd20; cpu_wdata = 8'h77; cpu_we = 1; #1;
    n_checks++;
    if (cpu_run !== 1'b0 || cycle_cnt !== 16'd10 || timeout !== 1'b0)
      $display("FAIL halt_state: run=%b cnt=%0d to=%b, required 0/10/0", cpu_run, cycle_cnt, timeout);
    else n_pass++;
    n_checks++;
    if (ram_we !== 1'b0 || cpu_rdata !== 8'd0 || ld_ready !== 1'b0)
      $display("FAIL halt_bus: we=%b rdata=%h ld_ready=%b, required 0/00/0", ram_we, cpu_rdata, ld_ready);
    else n_pass++;
    next_cycle;
    cpu_addr = 8'd240;
    next_cycle;
    next_cycle;
    cpu_we = 0; #1;
    n_checks++;
    if (io_out !== 32'hC300A500 || cycle_cnt !== 16'd10 || cpu_run !== 1'b0)
      $display("FAIL halt_hold: io=%h cnt=%0d run=%b, required c300a500/10/0", io_out, cycle_cnt, cpu_run);
    else n_pass++;
  endtask

  task automatic test_mid_load_reset;
    set_idle;
    rst_n = 0;
    next_cycle;
    rst_n = 1; #1;
    n_checks++;
    if (io_out !== 32'd0 || cycle_cnt !== 16'd0 || timeout !== 1'b0 || ld_ready !== 1'b1)
      $display("FAIL reset_from_halt: io=%h cnt=%0d to=%b ld_ready=%b, required 0/0/0/1",
               io_out, cycle_cnt, timeout, ld_ready);
    else n_pass++;
    load_bytes(0, 100, 8'h55, 1'b0);
    rst_n = 0; ld_valid = 1; ld_data = 8'hEE; #1;
    n_checks++;
    if (ram_we !== 1'b0 || ld_ready !== 1'b0)
      $display("FAIL mid_reset_bus: ram_we=%b ld_ready=%b, required 0/0", ram_we, ld_ready);
    else n_pass++;
    next_cycle;
    rst_n = 1; #1;
    n_checks++;
    if (ram_we !== 1'b1 || ram_addr !== 8'd0 || ram_din !== 8'hEE)
      $display("FAIL restart_addr: we=%b addr=%0d din=%h, required 1/0/ee", ram_we, ram_addr, ram_din);
    else n_pass++;
    next_cycle;
    ld_valid = 0; #1;
    n_checks++;
    if (mem[0] !== 8'hEE || mem[1] !== 8'h54 || mem[99] !== 8'h36)
      $display("FAIL ram_kept: m0=%h m1=%h m99=%h, required ee/54/36", mem[0], mem[1], mem[99]);
    else n_pass++;
    load_bytes(1, 239, 8'hAA, 1'b0);
  endtask

  task automatic test_timeout;
    int run_cycles;
    int guard;
    set_idle;
    run_cycles = 0; guard = 0;
    #1;
    while (cpu_run === 1'b1 && guard < 9000) begin
      run_cycles++; guard++;
      next_cycle; #1;
    end
    n_checks++;
    if (run_cycles != 8500)
      $display("FAIL timeout_len: run cycles=%0d, required 8500", run_cycles);
    else n_pass++;
    n_checks++;
    if (cycle_cnt !== 16'd8499 || timeout !== 1'b1 || cpu_run !== 1'b0)
      $display("FAIL timeout_state: cnt=%0d to=%b run=%b, required 8499/1/0", cycle_cnt, timeout, cpu_run);
    else n_pass++;
    next_cycle; next_cycle; #1;
    n_checks++;
    if (cycle_cnt !== 16'd8499 || timeout !== 1'b1)
      $display("FAIL timeout_hold: cnt=%0d to=%b, required 8499/1", cycle_cnt, timeout);
    else n_pass++;
  endtask

  task automatic test_halt_at_timeout;
    set_idle;
    rst_n = 0;
    next_cycle;
    rst_n = 1;
    load_bytes(0, 240, 8'h00, 1'b0);
    cyc = 0;
    while (cyc < 8499) next_cycle;
    #1;
    n_checks++;
    if (cycle_cnt !== 16'd8499 || cpu_run !== 1'b1)
      $display("FAIL last_run_cycle: cnt=%0d run=%b, required 8499/1", cycle_cnt, cpu_run);
    else n_pass++;
    cpu_halt = 1; cpu_we = 1; cpu_addr = 8'd242; cpu_wdata = 8'h99;
    next_cycle;
    set_idle; #1;
    n_checks++;
    if (cpu_run !== 1'b0 || timeout !== 1'b1 || cycle_cnt !== 16'd8499)
      $display("FAIL coincident_halt: run=%b to=%b cnt=%0d, required 0/1/8499", cpu_run, timeout, cycle_cnt);
    else n_pass++;
    n_checks++;
    if (io_out !== 32'h00990000)
      $display("FAIL final_cycle_write: io=%h, required 00990000", io_out);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_load;
    test_io_map;
    test_halt_request;
    test_mid_load_reset;
    test_timeout;
    test_halt_at_timeout;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
